// File: rtl/burst_wr_ctrl_if.sv
// Request, show-ahead FIFO and Avalon-MM burst write signals of burst_wr_ctrl.
// The controller uses the master modport; the surrounding logic uses slave.
interface burst_wr_ctrl_if #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 32,
  parameter int MAX_BURST = 16,
  parameter int LEN_W     = 16
);
  localparam int BYTES = DATA_W / 8;
  localparam int BC_W  = $clog2(MAX_BURST) + 1;

  logic              start;
  logic [LEN_W-1:0]  len;
  logic [ADDR_W-1:0] dst_addr;
  logic [ADDR_W-1:0] ring_base;
  logic [ADDR_W-1:0] ring_limit;
  logic              busy;
  logic              done;
  logic              fifo_empty;
  logic [DATA_W-1:0] fifo_data;
  logic              fifo_rd;
  logic [ADDR_W-1:0] address;
  logic              write;
  logic [DATA_W-1:0] writedata;
  logic [BYTES-1:0]  byteenable;
  logic [BC_W-1:0]   burstcount;
  logic              waitrequest;

  modport master (
    input  start, len, dst_addr, ring_base, ring_limit,
    input  fifo_empty, fifo_data, waitrequest,
    output busy, done, fifo_rd, address, write, writedata, byteenable, burstcount
  );

  modport slave (
    output start, len, dst_addr, ring_base, ring_limit,
    output fifo_empty, fifo_data, waitrequest,
    input  busy, done, fifo_rd, address, write, writedata, byteenable, burstcount
  );
endinterface

// File: rtl/burst_wr_ctrl.sv
// Drains a packet from a show-ahead FIFO into a ring buffer as Avalon-MM write
// bursts; bursts are cut at MAX_BURST beats and at the ring limit.
module burst_wr_ctrl #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 32,
  parameter int MAX_BURST = 16,
  parameter int LEN_W     = 16
) (
  input logic             clk,
  input logic             reset,
  burst_wr_ctrl_if.master bus
);
  localparam int BYTES = DATA_W / 8;
  localparam int BC_W  = $clog2(MAX_BURST) + 1;
  localparam int SH    = $clog2(BYTES);

  typedef enum logic [1:0] {IDLE, SETUP, BURST, DONE} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] cur_addr_q, cur_addr_d;
  logic [ADDR_W-1:0] address_q, address_d;
  logic [LEN_W-1:0]  words_left_q, words_left_d;
  logic [BC_W-1:0]   burstcount_q, burstcount_d;
  logic [BC_W-1:0]   beats_left_q, beats_left_d;
  logic              done_q, done_d;
  logic [ADDR_W-1:0] base_q, limit_q;
  logic [BYTES-1:0]  last_be_q;

  logic [LEN_W-1:0]  rem;
  logic [LEN_W-1:0]  start_words;
  logic [BYTES-1:0]  start_be;
  logic [ADDR_W-1:0] room;
  logic [ADDR_W-1:0] end_addr;
  logic [ADDR_W-1:0] wrap_addr;
  logic [BC_W-1:0]   bc_calc;
  logic              accept;
  logic              latch;

  // Word count and final-beat byte mask derived from the requested length.
  always_comb begin
    rem         = bus.len & LEN_W'(BYTES - 1);
    start_words = (bus.len >> SH) + LEN_W'(rem != '0);
    for (int b = 0; b < BYTES; b++) begin
      start_be[b] = (rem == '0) || (LEN_W'(b) < rem);
    end
  end

  always_comb begin
    room    = (limit_q - cur_addr_q) >> SH;
    bc_calc = BC_W'(MAX_BURST);
    if (room < ADDR_W'(MAX_BURST)) bc_calc = BC_W'(room);
    if (words_left_q < LEN_W'(bc_calc)) bc_calc = BC_W'(words_left_q);
    end_addr  = address_q + (ADDR_W'(burstcount_q) << SH);
    wrap_addr = (end_addr == limit_q) ? base_q : end_addr;
  end

  assign accept = (state_q == BURST) && !bus.fifo_empty && !bus.waitrequest;

  always_comb begin
    state_d      = state_q;
    cur_addr_d   = cur_addr_q;
    address_d    = address_q;
    words_left_d = words_left_q;
    burstcount_d = burstcount_q;
    beats_left_d = beats_left_q;
    done_d       = 1'b0;
    latch        = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          latch        = 1'b1;
          cur_addr_d   = bus.dst_addr;
          words_left_d = start_words;
          state_d      = (start_words != '0) ? SETUP : DONE;
        end
      end
      SETUP: begin
        address_d    = cur_addr_q;
        burstcount_d = bc_calc;
        beats_left_d = bc_calc;
        state_d      = BURST;
      end
      BURST: begin
        if (accept) begin
          words_left_d = words_left_q - LEN_W'(1);
          beats_left_d = beats_left_q - BC_W'(1);
          if (beats_left_q == BC_W'(1)) begin
            cur_addr_d = wrap_addr;
            state_d    = (words_left_q != LEN_W'(1)) ? SETUP : DONE;
          end
        end
      end
      DONE: begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= IDLE;
      cur_addr_q   <= '0;
      address_q    <= '0;
      words_left_q <= '0;
      burstcount_q <= '0;
      beats_left_q <= '0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cur_addr_q   <= cur_addr_d;
      address_q    <= address_d;
      words_left_q <= words_left_d;
      burstcount_q <= burstcount_d;
      beats_left_q <= beats_left_d;
      done_q       <= done_d;
    end
  end

  // Ring bounds and tail mask only matter while a transfer is active.
  always_ff @(posedge clk) begin
    if (latch) begin
      base_q    <= bus.ring_base;
      limit_q   <= bus.ring_limit;
      last_be_q <= start_be;
    end
  end

  assign bus.write      = (state_q == BURST) && !bus.fifo_empty;
  assign bus.writedata  = bus.fifo_data;
  assign bus.fifo_rd    = accept;
  assign bus.byteenable = (state_q != BURST) ? '0 :
                          (words_left_q == LEN_W'(1)) ? last_be_q : '1;
  assign bus.busy       = (state_q != IDLE);
  assign bus.done       = done_q;
  assign bus.address    = address_q;
  assign bus.burstcount = burstcount_q;
endmodule

// File: tb/tb_burst_wr_ctrl.sv
// Bench for burst_wr_ctrl: directed vector table, hand-written corner sequences
// and randomized transfers against a transfer-level burst/beat model.
module tb_burst_wr_ctrl;
  localparam int DATA_W    = 32;
  localparam int ADDR_W    = 32;
  localparam int MAX_BURST = 16;
  localparam int LEN_W     = 16;
  localparam int BYTES     = 4;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  burst_wr_ctrl_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .MAX_BURST(MAX_BURST), .LEN_W(LEN_W)) bus ();

  burst_wr_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .MAX_BURST(MAX_BURST), .LEN_W(LEN_W)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [15:0] len;
    logic [31:0] dst, base, limit;
    int          e_pct, w_pct;
    int          nb;
    logic [31:0] faddr;
    int          fbc;
    logic [31:0] laddr;
    int          lbc;
    logic [3:0]  lbe;
  } vec_t;

  typedef struct {
    int          nb;
    logic [31:0] faddr, laddr;
    int          fbc, lbc;
    logic [3:0]  lbe;
    int          rd;
    int          waitc;
  } res_t;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.start       = 1'b0;
    bus.len         = '0;
    bus.dst_addr    = '0;
    bus.ring_base   = '0;
    bus.ring_limit  = '0;
    bus.fifo_empty  = 1'b1;
    bus.fifo_data   = '0;
    bus.waitrequest = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_busy"},       bus.busy, 0);
    chk({tag, "_done"},       bus.done, 0);
    chk({tag, "_write"},      bus.write, 0);
    chk({tag, "_fifo_rd"},    bus.fifo_rd, 0);
    chk({tag, "_burstcount"}, bus.burstcount, 0);
    chk({tag, "_address"},    bus.address, 0);
    chk({tag, "_byteenable"}, bus.byteenable, 0);
  endtask

  // One transfer: builds the expected burst list from the ring rules, feeds the
  // FIFO, and checks every cycle until done (or until rst_beat beats, then resets).
  task automatic run_xfer(input logic [15:0] l, input logic [31:0] d, input logic [31:0] b,
                          input logic [31:0] lim, input int e_pct, input int w_pct,
                          input int wait_beat, input int wait_n, input int empty_beat,
                          input int empty_n, input int rst_beat, output res_t r);
    int words, left, room, bc, beat_idx, burst_idx, bib, t, bound, last_acc_t;
    int wait_left, empty_left;
    logic [31:0] cur, p_addr, p_data;
    logic [31:0] ea[$];
    int          eb[$];
    logic [31:0] ed[$];
    logic [31:0] fq[$];
    logic [3:0]  lbe, p_be;
    bit          in_burst, pww, finished, forced_e;

    r = '{default: 0};
    words = (int'(l) + BYTES - 1) / BYTES;
    left  = words;
    cur   = d;
    while (left > 0) begin
      room = int'((lim - cur) / BYTES);
      bc   = (left < MAX_BURST) ? left : MAX_BURST;
      if (room < bc) bc = room;
      if (bc <= 0) break;
      ea.push_back(cur);
      eb.push_back(bc);
      cur = cur + 32'(bc * BYTES);
      if (cur == lim) cur = b;
      left -= bc;
    end
    lbe = ((l % 4) == 0) ? 4'hF : 4'((1 << (l % 4)) - 1);
    for (int i = 0; i < words; i++) ed.push_back($urandom);
    fq = ed;

    beat_idx = 0; burst_idx = 0; bib = 0; last_acc_t = 0;
    wait_left = wait_n; empty_left = empty_n;
    in_burst = 0; pww = 0; finished = 0;
    p_addr = '0; p_data = '0; p_be = '0;
    bound = 100 + 10 * words;

    bus.start       = 1'b1;
    bus.len         = l;
    bus.dst_addr    = d;
    bus.ring_base   = b;
    bus.ring_limit  = lim;
    bus.fifo_empty  = 1'b1;
    bus.waitrequest = 1'b0;
    @(negedge clk);
    chk("idle_busy", bus.busy, 0);
    chk("idle_write", bus.write, 0);
    next_cycle();
    bus.start      = 1'b0;
    bus.len        = 16'($urandom);
    bus.dst_addr   = $urandom;
    bus.ring_base  = $urandom;
    bus.ring_limit = $urandom;

    for (t = 1; t <= bound && !finished; t++) begin
      if (rst_beat >= 0 && beat_idx == rst_beat) begin
        reset           = 1'b0;
        bus.waitrequest = 1'b1;
        bus.fifo_empty  = (fq.size() == 0);
        bus.fifo_data   = (fq.size() != 0) ? fq[0] : 32'h0;
        @(negedge clk);
        chk("rst_cycle_fifo_rd", bus.fifo_rd, 0);
        next_cycle();
        reset           = 1'b1;
        bus.waitrequest = 1'b0;
        @(negedge clk);
        chk_reset_outputs("midburst_rst");
        for (int k = 0; k < 3; k++) begin
          next_cycle();
          @(negedge clk);
          chk("post_rst_write", bus.write, 0);
          chk("post_rst_busy", bus.busy, 0);
        end
        next_cycle();
        idle_inputs();
        return;
      end

      bus.waitrequest = (int'($urandom_range(99)) < w_pct);
      if (beat_idx == wait_beat && wait_left > 0) bus.waitrequest = 1'b1;
      forced_e = (beat_idx == empty_beat && empty_left > 0);
      if (fq.size() == 0)                         bus.fifo_empty = 1'b1;
      else if (pww)                               bus.fifo_empty = 1'b0;
      else if (forced_e)                          bus.fifo_empty = 1'b1;
      else bus.fifo_empty = (int'($urandom_range(99)) < e_pct);
      bus.fifo_data = (fq.size() != 0) ? fq[0] : $urandom;

      @(negedge clk);
      if (bus.fifo_empty) chk("write_when_empty", bus.write, 0);
      else if (in_burst)  chk("write_follows_fifo", bus.write, 1);
      chk("fifo_rd_eq_accept", bus.fifo_rd, bus.write && !bus.waitrequest);
      if (pww && bus.write) begin
        chk("hold_address", bus.address, p_addr);
        chk("hold_writedata", bus.writedata, p_data);
        chk("hold_byteenable", bus.byteenable, p_be);
      end
      if (!bus.done) chk("busy_during_xfer", bus.busy, 1);

      if (bus.write) begin
        if (burst_idx >= ea.size()) begin
          chk("extra_burst_index", burst_idx, ea.size() - 1);
        end else begin
          if (!in_burst) begin
            if (burst_idx == 0) begin
              chk("first_write_latency_ok", t >= 2, 1);
              r.faddr = bus.address;
              r.fbc   = int'(bus.burstcount);
            end
            r.laddr  = bus.address;
            r.lbc    = int'(bus.burstcount);
            r.nb++;
            in_burst = 1;
          end
          chk("burst_address", bus.address, ea[burst_idx]);
          chk("burstcount", bus.burstcount, eb[burst_idx]);
          if (beat_idx < words) begin
            chk("writedata", bus.writedata, ed[beat_idx]);
            chk("byteenable", bus.byteenable, (beat_idx == words - 1) ? lbe : 4'hF);
          end
        end
        if (bus.waitrequest) r.waitc++;
        if (beat_idx == wait_beat && wait_left > 0) wait_left--;
      end
      if (forced_e) empty_left--;

      if (bus.fifo_rd) begin
        if (beat_idx == words - 1) r.lbe = bus.byteenable;
        if (fq.size() != 0) void'(fq.pop_front());
        beat_idx++;
        r.rd++;
        bib++;
        if (burst_idx < eb.size() && bib == eb[burst_idx]) begin
          burst_idx++;
          bib        = 0;
          in_burst   = 0;
          last_acc_t = t;
        end
      end

      if (bus.done) begin
        chk("done_beats", beat_idx, words);
        chk("done_bursts", burst_idx, ea.size());
        chk("done_latency", t, (words == 0) ? 2 : last_acc_t + 2);
        finished = 1;
      end
      pww    = bus.write && bus.waitrequest;
      p_addr = bus.address;
      p_data = bus.writedata;
      p_be   = bus.byteenable;
      next_cycle();
    end

    if (!finished) begin
      n_cmp++;
      n_bad++;
      $display("FAIL transfer_timeout: no done within %0d cycles (beats %0d of %0d)", bound, beat_idx, words);
    end
    @(negedge clk);
    chk("done_one_cycle", bus.done, 0);
    chk("idle_after_done", bus.busy, 0);
    next_cycle();
    idle_inputs();
  endtask

  initial begin
    vec_t vt[7];
    res_t r;
    logic [15:0] rl;
    logic [31:0] rb, rd_addr;
    int nblk;

    idle_inputs();
    reset          = 1'b0;
    bus.start      = 1'b1;
    bus.len        = 16'd8;
    bus.fifo_empty = 1'b0;
    repeat (3) next_cycle();
    @(negedge clk);
    chk_reset_outputs("por");
    next_cycle();
    reset = 1'b1;
    idle_inputs();
    next_cycle();

    vt[0] = '{16'd64,    32'h1000, 32'h0,    32'h10000, 0,  0,  1,    32'h1000, 16, 32'h1000, 16, 4'hF};
    vt[1] = '{16'd70,    32'h1000, 32'h0,    32'h10000, 0,  0,  2,    32'h1000, 16, 32'h1040, 2,  4'h3};
    vt[2] = '{16'd32,    32'h1070, 32'h1000, 32'h1080,  0,  0,  2,    32'h1070, 4,  32'h1000, 4,  4'hF};
    vt[3] = '{16'd1,     32'h2000, 32'h0,    32'h10000, 0,  0,  1,    32'h2000, 1,  32'h2000, 1,  4'h1};
    vt[4] = '{16'd0,     32'h3000, 32'h0,    32'h10000, 0,  0,  0,    32'h0,    0,  32'h0,    0,  4'h0};
    vt[5] = '{16'd67,    32'h1040, 32'h1000, 32'h1080,  25, 25, 2,    32'h1040, 16, 32'h1000, 1,  4'h7};
    vt[6] = '{16'hFFFF,  32'h0,    32'h0,    32'h10000, 0,  0,  1024, 32'h0,    16, 32'hFFC0, 16, 4'h7};

    for (int i = 0; i < 7; i++) begin
      run_xfer(vt[i].len, vt[i].dst, vt[i].base, vt[i].limit, vt[i].e_pct, vt[i].w_pct,
               -1, 0, -1, 0, -1, r);
      chk($sformatf("v%0d_nbursts", i), r.nb, vt[i].nb);
      chk($sformatf("v%0d_first_addr", i), r.faddr, vt[i].faddr);
      chk($sformatf("v%0d_first_bc", i), r.fbc, vt[i].fbc);
      chk($sformatf("v%0d_last_addr", i), r.laddr, vt[i].laddr);
      chk($sformatf("v%0d_last_bc", i), r.lbc, vt[i].lbc);
      chk($sformatf("v%0d_last_be", i), r.lbe, vt[i].lbe);
    end

    // waitrequest held for three cycles on beat 5
    run_xfer(16'd64, 32'h1000, 32'h0, 32'h10000, 0, 0, 5, 3, -1, 0, -1, r);
    chk("wait_rd_count", r.rd, 16);
    chk("wait_stall_cycles", r.waitc, 3);
    chk("wait_nbursts", r.nb, 1);

    // FIFO runs dry for two cycles on beat 8
    run_xfer(16'd64, 32'h1000, 32'h0, 32'h10000, 0, 0, -1, 0, 8, 2, -1, r);
    chk("empty_nbursts", r.nb, 1);
    chk("empty_addr", r.faddr, 32'h1000);
    chk("empty_bc", r.fbc, 16);
    chk("empty_rd_count", r.rd, 16);

    // reset after seven beats, then a clean transfer
    run_xfer(16'd64, 32'h1000, 32'h0, 32'h10000, 0, 0, -1, 0, -1, 0, 7, r);
    chk("rst_beats_before", r.rd, 7);
    run_xfer(16'd70, 32'h1000, 32'h0, 32'h10000, 0, 0, -1, 0, -1, 0, -1, r);
    chk("after_rst_nbursts", r.nb, 2);
    chk("after_rst_rd", r.rd, 18);
    chk("after_rst_last_be", r.lbe, 4'h3);

    for (int i = 0; i < 25; i++) begin
      nblk    = int'($urandom_range(1, 6));
      rb      = 32'(64 * $urandom_range(0, 1000));
      rd_addr = rb + 32'(4 * $urandom_range(0, 16 * nblk - 1));
      rl      = 16'($urandom_range(0, 400));
      run_xfer(rl, rd_addr, rb, rb + 32'(64 * nblk), 20, 20, -1, 0, -1, 0, -1, r);
      chk($sformatf("rnd%0d_rd", i), r.rd, (int'(rl) + 3) / 4);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/burst_wr_ctrl.md
BURST_WR_CTRL -- requirements
Module: burst_wr_ctrl

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
- DATA_W, 32, data bus width in bits; multiple of 8.
- ADDR_W, 32, byte address width.
- MAX_BURST, 16, maximum beats per burst; power of 2.
- LEN_W, 16, byte-length field width.
REQ-002 Derived widths SHALL be: BYTES = DATA_W/8; BC_W = clog2(MAX_BURST)+1.
REQ-003 Ports SHALL be, one per line (name, direction, width, meaning):
- clk, in, 1, clock.
- reset, in, 1, synchronous active-low reset.
- start, in, 1, transfer request.
- len, in, LEN_W, packet length in bytes.
- dst_addr, in, ADDR_W, first byte address; BYTES-aligned.
- ring_base, in, ADDR_W, ring start; aligned to BYTES*MAX_BURST.
- ring_limit, in, ADDR_W, ring end, exclusive; aligned to BYTES*MAX_BURST.
- busy, out, 1, transfer in progress.
- done, out, 1, one-cycle completion pulse.
- fifo_empty, in, 1, show-ahead FIFO has no word.
- fifo_data, in, DATA_W, head word; valid while !fifo_empty.
- fifo_rd, out, 1, pop head word.
- address, out, ADDR_W, Avalon burst start address.
- write, out, 1, Avalon write.
- writedata, out, DATA_W, Avalon data.
- byteenable, out, BYTES, Avalon byte enables.
- burstcount, out, BC_W, Avalon beats in the current burst.
- waitrequest, in, 1, Avalon slave stall.

Function
REQ-004 FSM SHALL have states IDLE, SETUP, BURST, DONE.
REQ-005 IDLE: start=1 SHALL latch len, dst_addr, ring_base and ring_limit, and SHALL compute words = ceil(len/BYTES).
- words>0 -> SETUP; words=0 -> DONE.
REQ-006 start SHALL be ignored outside IDLE.
REQ-007 SETUP SHALL last one cycle and SHALL set burstcount = min(words_left, MAX_BURST, (ring_limit-cur_addr)/BYTES).
- Same cycle: address <= cur_addr; -> BURST.
REQ-008 BURST: write SHALL equal !fifo_empty.
- writedata SHALL equal fifo_data (combinational passthrough).
- address and burstcount SHALL remain constant for the whole burst.
REQ-009 Beat acceptance SHALL be write && !waitrequest.
- fifo_rd SHALL be 1 exactly on an accepted beat, in the same cycle.
- Beat counter and words_left SHALL decrement by 1 per accepted beat.
REQ-010 While waitrequest=1, write, writedata, byteenable and address SHALL hold; fifo_rd SHALL be 0.
REQ-011 fifo_empty mid-burst SHALL drop write to 0; the burst SHALL resume without re-issuing address when data returns.
REQ-012 byteenable SHALL be all ones, except on the final beat of the transfer.
- Final beat with len mod BYTES = r != 0: low r bits = 1, remaining bits = 0.
REQ-013 Last accepted beat of a burst SHALL set cur_addr += burstcount*BYTES.
- If the result equals ring_limit, cur_addr SHALL become ring_base.
- Then: words_left>0 -> SETUP; else -> DONE.
REQ-014 A burst SHALL never cross ring_limit.
REQ-015 DONE SHALL assert done for one cycle, then go to IDLE.
REQ-016 busy SHALL be 1 in SETUP, BURST and DONE; 0 in IDLE.
REQ-017 Arithmetic: address math SHALL be modulo 2^ADDR_W; words_left SHALL be LEN_W bits wide; len = 2^LEN_W-1 SHALL be legal.
REQ-018 Latency: start at cycle N SHALL give first write assertion no earlier than N+2 (SETUP at N+1).

Reset
REQ-019 reset=0 at a clock edge SHALL force the following, in any state including mid-burst, with no further beats:
- state = IDLE.
- busy = 0, done = 0, write = 0, fifo_rd = 0.
- burstcount = 0, address = 0, byteenable = 0.
- Internal counters = 0.
REQ-020 Discarding unconsumed FIFO words after reset SHALL be the upstream block's responsibility.

Verification
REQ-021 Defaults, FIFO always non-empty, waitrequest=0, len=64, dst=0x1000 -> one burst: burstcount=16, address 0x1000, 16 consecutive beats, done pulse two cycles after the last beat.
REQ-022 len=70, dst=0x1000 -> two bursts:
- First: 16 beats at 0x1000.
- Second: burstcount=2 at 0x1040, final byteenable=4'b0011.
REQ-023 ring_base=0x1000, ring_limit=0x1080, dst=0x1070, len=32 -> two bursts:
- burstcount=4 at 0x1070.
- burstcount=4 at 0x1000.
REQ-024 waitrequest=1 for 3 cycles at beat 5 -> write, writedata and address stable for those cycles; fifo_rd=0; total fifo_rd count = 16.
REQ-025 fifo_empty=1 for 2 cycles mid-burst -> write=0 for those cycles; burst completes with the same address and burstcount.
REQ-026 Two further cases:
- len=0 -> done pulse at N+2, no write.
- reset=0 at beat 7 -> all outputs at reset values next cycle; a new start then completes normally.
